lap_memory: RTL and testbench

- Sits between internal_timer and lcd_bridge in the stopwatch datapath.
- Captures the running timestamp on each lap request into a circular buffer of DEPTH entries.
- Serves random-access reads of stored laps to the display path.
- Drives reg_busy back to key_logic_fsm so that key actions are held off during capture or clear.

---
 rtl/lap_memory.sv | 127 ++++++++++++
 tb/tb_lap_memory.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_memory.sv
// lap_memory: lap timestamp ring buffer with aged random-access reads; define LAP_MEMORY_DELTA_EN to store splits instead of absolute times
module lap_memory #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int TS_W  = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TS_W-1:0]  timestamp,
  input  logic             lap_req,
  input  logic             clear_req,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TS_W-1:0]  rd_data,
  output logic             rd_hit,
  output logic [IDX_W:0]   lap_count,
  output logic             full,
  output logic             reg_busy
);
  typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR} state_t;
  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  state_t state, next_state;
  logic armed, lap_q, clr_q, lap_pend, clr_pend;
  logic lap_edge, clr_edge, enter_capture, enter_clear, clear_done;
  logic hit, s1_valid, s1_hit;
  logic [IDX_W-1:0] wr_ptr, clr_ptr, rd_addr;
  logic [TS_W-1:0] entry, s1_data;
  logic [TS_W-1:0] mem [DEPTH];
  assign lap_edge      = armed & lap_req & ~lap_q;
  assign clr_edge      = armed & clear_req & ~clr_q;
  assign enter_clear   = state == IDLE && clr_pend;
  assign enter_capture = state == IDLE && !clr_pend && lap_pend;
  assign clear_done    = state == CLEAR && clr_ptr == LAST;
  assign reg_busy      = state != IDLE;
  assign full          = lap_count == DEPTH_C;
  assign rd_addr       = wr_ptr - IDX_W'(1) - rd_idx;
  assign hit           = rd_req && state != CLEAR && {1'b0, rd_idx} < lap_count;
`ifdef LAP_MEMORY_DELTA_EN
  logic [TS_W-1:0] lap_prev;
  logic [7:0] f_ms, f_s, f_m, f_h;
  function automatic logic [7:0] sub_field(input logic [6:0] a, input logic [6:0] b, input logic bin, input logic [6:0] radix);
    logic [7:0] d;
    logic [6:0] w;
    d = {1'b0, a} - {1'b0, b} - {7'd0, bin};
    w = d[6:0] + radix;
    return d[7] ? {1'b1, w} : {1'b0, d[6:0]};
  endfunction
  // split against the previous capture with per-field borrow; a negative total keeps absolute time
  always_comb begin
    f_ms  = sub_field(timestamp[6:0], lap_prev[6:0], 1'b0, 7'd100);
    f_s   = sub_field(timestamp[13:7], lap_prev[13:7], f_ms[7], 7'd60);
    f_m   = sub_field(timestamp[20:14], lap_prev[20:14], f_s[7], 7'd60);
    f_h   = sub_field(timestamp[27:21], lap_prev[27:21], f_m[7], 7'd100);
    entry = f_h[7] ? timestamp : {f_h[6:0], f_m[6:0], f_s[6:0], f_ms[6:0]};
  end
  // previous capture time, forgotten by a completed clear
  always_ff @(posedge clock or posedge reset)
    if (reset) lap_prev <= '0;
    else if (state == CAPTURE) lap_prev <= timestamp;
    else if (clear_done) lap_prev <= '0;
`else
  assign entry = timestamp;
`endif
  // request edge detection and one-deep pending flags; the first cycle after reset is masked so held levels never fire
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      armed    <= 1'b0;
      lap_q    <= 1'b0;
      clr_q    <= 1'b0;
      lap_pend <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      armed    <= 1'b1;
      lap_q    <= lap_req;
      clr_q    <= clear_req;
      clr_pend <= clr_edge | (clr_pend & ~enter_clear);
      lap_pend <= ~clr_edge & (lap_edge | (lap_pend & ~enter_capture));
    end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // next state: clear beats lap, capture lasts one cycle, clear walks every slot
  always_comb begin
    next_state = state == IDLE    ? (clr_pend ? CLEAR : lap_pend ? CAPTURE : IDLE) :
                 state == CAPTURE ? IDLE :
                 clear_done       ? IDLE : CLEAR;
  end
  // write pointer, wipe pointer and saturating entry count
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr    <= '0;
      clr_ptr   <= '0;
      lap_count <= '0;
    end else if (clear_done) begin
      wr_ptr    <= '0;
      clr_ptr   <= '0;
      lap_count <= '0;
    end else if (state == CLEAR) clr_ptr <= clr_ptr + IDX_W'(1);
    else if (state == CAPTURE) begin
      wr_ptr    <= wr_ptr + IDX_W'(1);
      lap_count <= full ? lap_count : lap_count + (IDX_W+1)'(1);
    end else if (enter_clear) clr_ptr <= '0;
  // lap storage, written by captures and zeroed by clears
  always_ff @(posedge clock)
    if (state == CAPTURE) mem[wr_ptr] <= entry;
    else if (state == CLEAR) mem[clr_ptr] <= '0;
  // two-stage read: the slot is sampled in the request cycle so a same-cycle capture returns old data
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_data  <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1_valid <= rd_req;
      s1_hit   <= hit;
      s1_data  <= hit ? mem[rd_addr] : '0;
      rd_valid <= s1_valid;
      rd_hit   <= s1_hit;
      rd_data  <= s1_data;
    end
endmodule

// File: tb/tb_lap_memory.sv
// tb_lap_memory: table and sequence checks of lap_memory against a scoreboarded reference model
module tb_lap_memory;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int TS_W  = 28;
`ifdef LAP_MEMORY_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif
  typedef struct { int idx; logic hit; logic [TS_W-1:0] data; } rd_vec_t;
  typedef struct { int due; logic hit; logic [TS_W-1:0] data; } sb_t;
  logic clock, reset, lap_req, clear_req, rd_req, rd_valid, rd_hit, full, reg_busy;
  logic [TS_W-1:0] timestamp, rd_data;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W:0] lap_count;
  int cyc, n_checks, n_fail, busy_cnt;
  sb_t sb[$];
  logic [TS_W-1:0] model_q[$];
  logic [TS_W-1:0] model_prev;
  rd_vec_t two_tab[3];
  rd_vec_t ten_tab[8];

  lap_memory #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TS_W(TS_W)) dut (
    .clock(clock), .reset(reset), .timestamp(timestamp), .lap_req(lap_req),
    .clear_req(clear_req), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_hit(rd_hit), .lap_count(lap_count), .full(full),
    .reg_busy(reg_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [TS_W-1:0] ts_of(int h, int m, int s, int ms);
    return {7'(h), 7'(m), 7'(s), 7'(ms)};
  endfunction

  function automatic int cs_of(logic [TS_W-1:0] t);
    return ((int'(t[27:21]) * 60 + int'(t[20:14])) * 60 + int'(t[13:7])) * 100 + int'(t[6:0]);
  endfunction

  function automatic logic [TS_W-1:0] model_entry(logic [TS_W-1:0] t);
    int d;
    d = cs_of(t) - cs_of(model_prev);
    return (DELTA && d >= 0) ? ts_of(d / 360000, d / 6000 % 60, d / 100 % 60, d % 100) : t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
      rd_req = 1'b0;
    end
  endtask

  task automatic model_capture(logic [TS_W-1:0] t);
    model_q.push_back(model_entry(t));
    if (model_q.size() > DEPTH) void'(model_q.pop_front());
    model_prev = t;
  endtask

  task automatic model_clear();
    model_q.delete();
    model_prev = '0;
  endtask

  task automatic issue_rd(int idx, logic hit, logic [TS_W-1:0] data);
    sb_t e;
    e.due  = cyc + 2;
    e.hit  = hit;
    e.data = data;
    sb.push_back(e);
    rd_idx = IDX_W'(idx);
    rd_req = 1'b1;
  endtask

  task automatic issue_model_rd(int idx);
    if (idx < model_q.size()) issue_rd(idx, 1'b1, model_q[model_q.size() - 1 - idx]);
    else issue_rd(idx, 1'b0, '0);
  endtask

  task automatic do_lap(logic [TS_W-1:0] t);
    timestamp = t;
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    chk("lap_wait_busy", 32'(reg_busy), 0);
    tick();
    chk("lap_capture_busy", 32'(reg_busy), 1);
    model_capture(t);
    tick();
    chk("lap_count_after", 32'(lap_count), model_q.size());
    chk("lap_done_busy", 32'(reg_busy), 0);
    tick(2);
  endtask

  always @(negedge clock) begin
    sb_t e;
    if (rd_valid) begin
      if (sb.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 0);
      else begin
        e = sb.pop_front();
        chk("rd_latency", cyc, e.due);
        chk("rd_hit", 32'(rd_hit), 32'(e.hit));
        chk("rd_data", 32'(rd_data), 32'(e.data));
      end
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      chk("rd_valid_missing", 32'(rd_valid), 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    two_tab[0] = '{0, 1'b1, DELTA ? ts_of(0, 0, 1, 85) : ts_of(0, 0, 3, 10)};
    two_tab[1] = '{1, 1'b1, ts_of(0, 0, 1, 25)};
    two_tab[2] = '{2, 1'b0, '0};
    for (int i = 0; i < 8; i++) ten_tab[i] = '{i, 1'b1, DELTA ? ts_of(0, 0, 0, 1) : ts_of(0, 0, 0, 10 - i)};
    model_prev = '0;
    reset = 1'b1;
    lap_req = 1'b1;
    clear_req = 1'b0;
    rd_req = 1'b0;
    rd_idx = '0;
    timestamp = ts_of(0, 0, 0, 7);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_lap_count", 32'(lap_count), 0);
    chk("reset_full", 32'(full), 0);
    chk("reset_busy", 32'(reg_busy), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_hit", 32'(rd_hit), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      busy_cnt += int'(reg_busy);
    end
    chk("held_lap_busy", busy_cnt, 0);
    chk("held_lap_count", 32'(lap_count), 0);
    lap_req = 1'b0;
    tick();
    issue_rd(0, 1'b0, '0);
    tick(4);

    do_lap(ts_of(0, 0, 1, 25));
    do_lap(ts_of(0, 0, 3, 10));
    chk("two_laps_count", 32'(lap_count), 2);
    chk("two_laps_full", 32'(full), 0);
    for (int i = 0; i < 3; i++) begin
      issue_rd(two_tab[i].idx, two_tab[i].hit, two_tab[i].data);
      tick();
    end
    tick(3);

    clear_req = 1'b1;
    lap_req = 1'b1;
    tick();
    clear_req = 1'b0;
    lap_req = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      busy_cnt += int'(reg_busy);
      if (i == 1) issue_rd(0, 1'b0, '0);
    end
    model_clear();
    chk("clear_busy_cycles", busy_cnt, 8);
    chk("clear_count", 32'(lap_count), 0);
    chk("clear_full", 32'(full), 0);
    issue_model_rd(0);
    tick(4);

    for (int k = 1; k <= 10; k++) do_lap(ts_of(0, 0, 0, k));
    chk("ten_laps_full", 32'(full), 1);
    chk("ten_laps_count", 32'(lap_count), 8);
    for (int i = 0; i < 8; i++) begin
      issue_rd(ten_tab[i].idx, ten_tab[i].hit, ten_tab[i].data);
      tick();
    end
    tick(3);

    timestamp = ts_of(0, 0, 0, 11);
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    tick();
    chk("coincide_busy", 32'(reg_busy), 1);
    issue_model_rd(7);
    tick();
    model_capture(timestamp);
    tick(3);
    issue_model_rd(0);
    tick();
    issue_model_rd(7);
    tick(4);

    timestamp = ts_of(0, 0, 0, 20);
    lap_req = 1'b1;
    tick();
    lap_req = 1'b0;
    chk("double_wait_busy", 32'(reg_busy), 0);
    tick();
    chk("double_first_busy", 32'(reg_busy), 1);
    lap_req = 1'b1;
    model_capture(timestamp);
    tick();
    lap_req = 1'b0;
    chk("double_gap_busy", 32'(reg_busy), 0);
    timestamp = ts_of(0, 0, 0, 21);
    tick();
    chk("double_second_busy", 32'(reg_busy), 1);
    model_capture(timestamp);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      busy_cnt += int'(reg_busy);
    end
    chk("double_no_third", busy_cnt, 0);
    issue_model_rd(0);
    tick();
    issue_model_rd(1);
    tick(4);

    clear_req = 1'b1;
    timestamp = ts_of(0, 0, 2, 30);
    tick();
    clear_req = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      busy_cnt += int'(reg_busy);
      lap_req = (i == 1 || i == 3);
    end
    model_clear();
    model_capture(timestamp);
    chk("clear_drop_busy", busy_cnt, 9);
    chk("clear_drop_count", 32'(lap_count), 1);
    issue_model_rd(0);
    tick();
    issue_model_rd(1);
    tick(6);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
